// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator: syncs, blanking, coordinates, strobes, frame count
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 11,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output logic          animate,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_AFTER = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_AFTER = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] X_MAX    = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_MAX    = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_LO    = CW'(HS_FIRST);
    localparam logic [CW-1:0] HS_HI    = CW'(HS_AFTER);
    localparam logic [CW-1:0] VS_LO    = CW'(VS_FIRST);
    localparam logic [CW-1:0] VS_HI    = CW'(VS_AFTER);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_interval
            $error("vga_timing_gen: every timing interval must be at least 1");
        end
        if (CW < 1 || CW > 30 || (2 ** CW) <= H_TOTAL || (2 ** CW) <= V_TOTAL) begin : g_bad_cw
            $error("vga_timing_gen: CW too small for H_TOTAL or V_TOTAL");
        end
        if (FW < 1) begin : g_bad_fw
            $error("vga_timing_gen: FW must be at least 1");
        end
    endgenerate

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_end;
    logic          v_end;

    assign h_end = (h_count == H_LAST);
    assign v_end = (v_count == V_LAST);

    // The vertical wrap and frame increment share the edge on which the line wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count     <= '0;
            v_count     <= '0;
            frame_count <= '0;
        end else if (pix) begin
            if (h_end) begin
                h_count <= '0;
                if (v_end) begin
                    v_count     <= '0;
                    frame_count <= frame_count + FW'(1);
                end else begin
                    v_count <= v_count + CW'(1);
                end
            end else begin
                h_count <= h_count + CW'(1);
            end
        end
    end

    logic in_hsync;
    logic in_vsync;
    logic h_blank;
    logic v_blank;

    always_comb begin
        in_hsync    = (h_count >= HS_LO) && (h_count < HS_HI);
        in_vsync    = (v_count >= VS_LO) && (v_count < VS_HI);
        h_blank     = (h_count >= H_ACT_C);
        v_blank     = (v_count >= V_ACT_C);
        hs          = in_hsync ? HS_ON : ~HS_ON;
        vs          = in_vsync ? VS_ON : ~VS_ON;
        blank       = h_blank | v_blank;
        line_start  = (h_count == '0);
        frame_start = (h_count == '0) && (v_count == '0);
        animate     = h_end && (v_count == Y_MAX);
        // Coordinates clamp to the last visible column/row during blanking.
        x           = h_blank ? X_MAX : h_count;
        y           = v_blank ? Y_MAX : v_count;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator, the next generation of the fixed 640x480 sync block. It produces hsync/vsync with configurable polarity, a blanking flag, pixel coordinates, per-line, per-frame and animate strobes, and a frame counter. All horizontal and vertical timing intervals are parameters, so one block covers 640x480, 800x600 and small simulation rasters. It sits between the pixel-clock-enable source and the video/framebuffer pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
CW, 11, h/v counter width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)
FW, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix  in  1  pixel clock enable; counters advance only on clk edges with pix=1
hs  out  1  horizontal sync, level per HS_POL
vs  out  1  vertical sync, level per VS_POL
blank  out  1  1 outside the active area
line_start  out  1  high while h_count==0 (any line)
frame_start  out  1  high while h_count==0 and v_count==0
animate  out  1  high while h_count==H_TOTAL-1 and v_count==V_ACTIVE-1
x  out  CW  active-area column
y  out  CW  active-area row
frame_count  out  FW  completed-frame count, wraps

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Registered state: h_count and v_count (CW bits each) and frame_count. Region order within a line/frame: active, front porch, sync, back porch. Active starts at count 0.
- The clocked sequence applies only on clk edges with pix=1. With pix=0, all state holds.
- h_count increments each pix cycle; at H_TOTAL-1 it wraps to 0 and v_count increments.
- v_count wraps to 0 when both v_count==V_TOTAL-1 and h_count==H_TOTAL-1; frame_count increments modulo 2^FW on that same edge.
- No counter ever reaches H_TOTAL or V_TOTAL; the v wrap and h wrap happen on the same edge.
- Outputs are combinational decodes of the registered counters and are valid the cycle after each update:
  - hs = HS_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vs = VS_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. vs changes only when h_count==0.
  - blank = (h_count >= H_ACTIVE) | (v_count >= V_ACTIVE).
  - x = h_count when h_count < H_ACTIVE, else H_ACTIVE-1 (holds the last column).
  - y = v_count when v_count < V_ACTIVE, else V_ACTIVE-1.
- Strobe levels persist for the whole pix period; consumers qualify them with pix to get single-cycle events.
- Reset: h_count=0, v_count=0, frame_count=0. Reset takes priority over pix and takes effect mid-line or mid-frame.
- Post-reset outputs: hs=~HS_POL, vs=~VS_POL, blank=0, x=0, y=0, line_start=1, frame_start=1, animate=0, frame_count=0.
- Elaboration must reject any zero interval and any CW too small for H_TOTAL or V_TOTAL.

Test Plan:
- Defaults, pix=1 every clk, reset then run 800 cycles -> hs low for exactly h_count 656..751 (96 cycles); blank=1 from h=640; h wraps 799->0 and v goes 0->1.
- Defaults, run a full frame -> vs low only on lines 490..491; animate high for 1 cycle at (h=799, v=479); frame_start high again after exactly 420000 pix cycles; frame_count 0->1.
- Small raster (H 4/1/1/1, V 3/1/1/1, HS_POL=VS_POL=1), pix every 3rd clk -> state advances only on pix edges; hs high at h=5; x sequence 0,1,2,3,3,3,3; outputs constant across pix=0 gaps.
- FW=2, run 5 frames -> frame_count sequence 1,2,3,0,1.
- Assert rst at h=123, v=300 -> next cycle h=v=0, blank=0, line_start=frame_start=1, frame_count=0. rst together with pix=1 -> reset wins.
- During vertical blank (v=500) -> y=479, blank=1 for the entire line, x still sweeps 0..639 then holds 639.
